// File: rtl/alu_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_unit
// Description : Registered RISC-V execute block: instruction-field decoder
//               feeding a 32-bit ALU, one-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic            funct7b5_i,
    input  logic            bypass_i,
    input  logic [2:0]      alu_ctrl_i,
    output logic [XLEN-1:0] y_o,
    output logic            zero_o,
    output logic [2:0]      alu_ctrl_o,
    output logic            illegal_o,
    output logic            valid_o
);

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_XOR = 3'b010;
    localparam logic [2:0] c_ALU_SLL = 3'b011;
    localparam logic [2:0] c_ALU_SRL = 3'b100;
    localparam logic [2:0] c_ALU_SRA = 3'b101;
    localparam logic [2:0] c_ALU_OR  = 3'b110;
    localparam logic [2:0] c_ALU_AND = 3'b111;

    localparam logic [6:0] c_OPC_R      = 7'b0110011;
    localparam logic [6:0] c_OPC_I      = 7'b0010011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;

    logic [2:0]      w_ctrl;
    logic            w_illegal;
    logic [XLEN-1:0] w_y;
    logic [4:0]      w_shamt;

    logic [XLEN-1:0] r_y;
    logic            r_zero;
    logic [2:0]      r_ctrl;
    logic            r_illegal;
    logic            r_valid;

    always_comb begin
        w_ctrl    = c_ALU_ADD;
        w_illegal = 1'b0;
        if (bypass_i) begin
            w_ctrl = alu_ctrl_i;
        end else begin
            case (opcode_i)
                c_OPC_R, c_OPC_I: begin
                    case (funct3_i)
                        // funct7b5 selects SUB only for register-register ops
                        3'b000: w_ctrl = (funct7b5_i && opcode_i == c_OPC_R) ? c_ALU_SUB : c_ALU_ADD;
                        3'b001: w_ctrl = c_ALU_SLL;
                        3'b100: w_ctrl = c_ALU_XOR;
                        3'b101: w_ctrl = funct7b5_i ? c_ALU_SRA : c_ALU_SRL;
                        3'b110: w_ctrl = c_ALU_OR;
                        3'b111: w_ctrl = c_ALU_AND;
                        default: w_illegal = 1'b1;
                    endcase
                end
                c_OPC_LOAD, c_OPC_STORE: w_ctrl = c_ALU_ADD;
                c_OPC_BRANCH:            w_ctrl = c_ALU_SUB;
                default:                 w_illegal = 1'b1;
            endcase
        end
    end

    assign w_shamt = b_i[4:0];

    always_comb begin
        w_y = '0;
        case (w_ctrl)
            c_ALU_ADD: w_y = a_i + b_i;
            c_ALU_SUB: w_y = a_i - b_i;
            c_ALU_XOR: w_y = a_i ^ b_i;
            c_ALU_SLL: w_y = a_i << w_shamt;
            c_ALU_SRL: w_y = a_i >> w_shamt;
            c_ALU_SRA: w_y = $unsigned($signed(a_i) >>> w_shamt);
            c_ALU_OR:  w_y = a_i | b_i;
            c_ALU_AND: w_y = a_i & b_i;
            default:   w_y = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y       <= '0;
            r_zero    <= 1'b0;
            r_ctrl    <= c_ALU_ADD;
            r_illegal <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= valid_i;
            if (valid_i) begin
                r_y       <= w_y;
                r_zero    <= (w_y == '0);
                r_ctrl    <= w_ctrl;
                r_illegal <= w_illegal;
            end
        end
    end

    assign y_o        = r_y;
    assign zero_o     = r_zero;
    assign alu_ctrl_o = r_ctrl;
    assign illegal_o  = r_illegal;
    assign valid_o    = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_ctrl_unit
// Description : Self-checking bench for alu_ctrl_unit with directed and
//               random stimulus against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic [31:0] a_i, b_i;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic        funct7b5_i;
    logic        bypass_i;
    logic [2:0]  alu_ctrl_i;
    logic [31:0] y_o;
    logic        zero_o;
    logic [2:0]  alu_ctrl_o;
    logic        illegal_o;
    logic        valid_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] e_y;
    logic        e_z;
    logic [2:0]  e_c;
    logic        e_i;
    logic        e_v;

    alu_ctrl_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .a_i(a_i), .b_i(b_i),
        .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7b5_i(funct7b5_i),
        .bypass_i(bypass_i), .alu_ctrl_i(alu_ctrl_i), .y_o(y_o), .zero_o(zero_o),
        .alu_ctrl_o(alu_ctrl_o), .illegal_o(illegal_o), .valid_o(valid_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural model: decode via a funct3 table plus override rules, then plain arithmetic.
    function automatic void ref_exec(input logic [31:0] a, input logic [31:0] b,
                                     input logic [6:0] opc, input logic [2:0] f3,
                                     input logic f7, input logic byp, input logic [2:0] ctrl,
                                     output logic [2:0] op, output logic ill,
                                     output logic [31:0] y);
        logic [2:0] f3map [8] = '{3'd0, 3'd3, 3'd0, 3'd0, 3'd2, 3'd4, 3'd6, 3'd7};
        logic [63:0] sext;
        int sh;
        op  = 3'd0;
        ill = 1'b0;
        if (byp) op = ctrl;
        else if (opc == 7'h33 || opc == 7'h13) begin
            if (f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
            else begin
                op = f3map[f3];
                if (f3 == 3'd5 && f7) op = 3'd5;
                if (f3 == 3'd0 && f7 && opc == 7'h33) op = 3'd1;
            end
        end
        else if (opc == 7'h03 || opc == 7'h23) op = 3'd0;
        else if (opc == 7'h63) op = 3'd1;
        else ill = 1'b1;
        sh   = int'(b % 32);
        sext = {{32{a[31]}}, a};
        case (op)
            3'd0: y = a + b;
            3'd1: y = a + (~b + 32'd1);
            3'd2: y = a ^ b;
            3'd3: y = a * (32'd1 << sh);
            3'd4: y = a / (32'd1 << sh);
            3'd5: y = sext[sh +: 32];
            3'd6: y = a | b;
            default: y = a & b;
        endcase
    endfunction

    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                        input logic byp, input logic [2:0] ctrl);
        logic [2:0]  c;
        logic        il;
        logic [31:0] y;
        valid_i = v; a_i = a; b_i = b; opcode_i = opc; funct3_i = f3;
        funct7b5_i = f7; bypass_i = byp; alu_ctrl_i = ctrl;
        @(posedge clk);
        if (v) begin
            ref_exec(a, b, opc, f3, f7, byp, ctrl, c, il, y);
            e_y = y; e_z = (y == 32'd0); e_c = c; e_i = il;
        end
        e_v = v;
        #1;
        chk("y", y_o, e_y);
        chk("zero", {31'd0, zero_o}, {31'd0, e_z});
        chk("ctrl", {29'd0, alu_ctrl_o}, {29'd0, e_c});
        chk("illegal", {31'd0, illegal_o}, {31'd0, e_i});
        chk("valid", {31'd0, valid_o}, {31'd0, e_v});
    endtask

    task automatic model_reset();
        e_y = '0; e_z = 1'b0; e_c = 3'd0; e_i = 1'b0; e_v = 1'b0;
    endtask

    initial begin
        logic [6:0] opcs [6];
        logic [31:0] ra, rb;
        opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h00};
        rst_n = 1'b0; valid_i = 1'b0; a_i = '0; b_i = '0; opcode_i = '0;
        funct3_i = '0; funct7b5_i = 1'b0; bypass_i = 1'b0; alu_ctrl_i = '0;
        model_reset();
        #2;
        chk("rst_y", y_o, 32'd0);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_ctrl", {29'd0, alu_ctrl_o}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Bypass operations
        step(1, 32'd2, 32'd3, 7'h00, 3'd0, 0, 1, 3'b000);
        chk("add_5", y_o, 32'd5);
        step(1, 32'h10, 32'd4, 7'h00, 3'd0, 0, 1, 3'b001);
        chk("sub_12", y_o, 32'd12);
        step(1, 32'd7, 32'd7, 7'h00, 3'd0, 0, 1, 3'b001);
        chk("sub_zero", {31'd0, zero_o}, 32'd1);
        step(1, 32'h0F, 32'hF0, 7'h00, 3'd0, 0, 1, 3'b010);
        chk("xor_ff", y_o, 32'hFF);
        step(1, 32'd1, 32'd4, 7'h00, 3'd0, 0, 1, 3'b011);
        chk("sll_16", y_o, 32'd16);
        step(1, 32'd1, 32'd36, 7'h00, 3'd0, 0, 1, 3'b011);
        chk("sll_b40", y_o, 32'd16);

        // Decode path
        step(1, 32'h80000000, 32'd4, 7'h33, 3'b101, 1, 0, 3'b000);
        chk("sra_y", y_o, 32'hF8000000);
        chk("sra_ctrl", {29'd0, alu_ctrl_o}, 32'd5);
        step(1, 32'd5, 32'd1, 7'h13, 3'b000, 1, 0, 3'b111);
        chk("addi_6", y_o, 32'd6);
        step(1, 32'd9, 32'd9, 7'h63, 3'b000, 0, 0, 3'b000);
        chk("beq_zero", {31'd0, zero_o}, 32'd1);
        step(1, 32'd3, 32'd4, 7'h33, 3'b010, 0, 0, 3'b001);
        chk("ill_flag", {31'd0, illegal_o}, 32'd1);
        chk("ill_add", y_o, 32'd7);

        // Hold with changing operands
        step(1, 32'd100, 32'd23, 7'h33, 3'b000, 0, 0, 3'b000);
        for (int i = 0; i < 3; i++) begin
            step(0, $urandom, $urandom, 7'h33, 3'b000, 1, 0, 3'b000);
            chk("hold_y", y_o, 32'd123);
        end

        // Asynchronous reset mid-stream
        step(1, 32'd40, 32'd2, 7'h03, 3'b010, 0, 0, 3'b000);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_y", y_o, 32'd0);
        chk("arst_zero", {31'd0, zero_o}, 32'd0);
        chk("arst_ctrl", {29'd0, alu_ctrl_o}, 32'd0);
        chk("arst_ill", {31'd0, illegal_o}, 32'd0);
        chk("arst_valid", {31'd0, valid_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            logic [6:0] opc;
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            opc = opcs[$urandom_range(0, 5)];
            if (opc == 7'h00) opc = 7'($urandom);
            step(($urandom_range(0, 3) != 0), ra, rb, opc, 3'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), 3'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
